// File: rtl/decm_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | decm_if : fetch-to-decode and decode-to-execute handshake bundle          |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
interface decm_if;
  logic        input_valid_i;
  logic        input_ready_o;
  logic [31:0] instr_i;
  logic [31:0] pc_i;
  logic        output_ready_i;
  logic        output_valid_o;
  logic [31:0] pc_o;
  logic [3:0]  op_class_o;
  logic [4:0]  rd_o;
  logic [4:0]  rs1_o;
  logic [4:0]  rs2_o;
  logic [2:0]  func3_o;
  logic        alt_o;
  logic [31:0] imm_o;
  logic        branch_o;
  logic [19:0] boffset_o;

  modport master (
    output input_valid_i, instr_i, pc_i, output_ready_i,
    input  input_ready_o, output_valid_o, pc_o, op_class_o, rd_o, rs1_o,
           rs2_o, func3_o, alt_o, imm_o, branch_o, boffset_o
  );

  modport slave (
    input  input_valid_i, instr_i, pc_i, output_ready_i,
    output input_ready_o, output_valid_o, pc_o, op_class_o, rd_o, rs1_o,
           rs2_o, func3_o, alt_o, imm_o, branch_o, boffset_o
  );
endinterface
`default_nettype wire

// File: rtl/decm.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | decm : RV32I decode stage with registered two-entry skid output buffer    |
// | Optional early JAL redirect: ECAP5_DPROC_EARLY_JAL_EN                     |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module decm (
  input wire    clk_i,
  input wire    rst_ni,
  input wire    flush_i,
  decm_if.slave bus
);

  localparam logic [4:0] c_OP_LUI      = 5'b01101;
  localparam logic [4:0] c_OP_AUIPC    = 5'b00101;
  localparam logic [4:0] c_OP_JAL      = 5'b11011;
  localparam logic [4:0] c_OP_JALR     = 5'b11001;
  localparam logic [4:0] c_OP_BRANCH   = 5'b11000;
  localparam logic [4:0] c_OP_LOAD     = 5'b00000;
  localparam logic [4:0] c_OP_STORE    = 5'b01000;
  localparam logic [4:0] c_OP_OP_IMM   = 5'b00100;
  localparam logic [4:0] c_OP_OP       = 5'b01100;
  localparam logic [4:0] c_OP_MISC_MEM = 5'b00011;
  localparam logic [4:0] c_OP_SYSTEM   = 5'b11100;

  localparam logic [3:0] c_CLS_LUI      = 4'd0;
  localparam logic [3:0] c_CLS_AUIPC    = 4'd1;
  localparam logic [3:0] c_CLS_JAL      = 4'd2;
  localparam logic [3:0] c_CLS_JALR     = 4'd3;
  localparam logic [3:0] c_CLS_BRANCH   = 4'd4;
  localparam logic [3:0] c_CLS_LOAD     = 4'd5;
  localparam logic [3:0] c_CLS_STORE    = 4'd6;
  localparam logic [3:0] c_CLS_OP_IMM   = 4'd7;
  localparam logic [3:0] c_CLS_OP       = 4'd8;
  localparam logic [3:0] c_CLS_MISC_MEM = 4'd9;
  localparam logic [3:0] c_CLS_SYSTEM   = 4'd10;
  localparam logic [3:0] c_CLS_ILLEGAL  = 4'd15;

  typedef struct packed {
    logic [31:0] pc;
    logic [3:0]  cls;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic        alt;
    logic [31:0] imm;
  } bundle_t;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_BUSY  = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  logic [31:0] w_instr;
  logic [31:0] w_imm_i;
  logic [31:0] w_imm_s;
  logic [31:0] w_imm_b;
  logic [31:0] w_imm_u;
  logic [31:0] w_imm_j;
  bundle_t     w_dec;
  logic        w_accept;
  logic        w_fire;
  logic        w_load;

  state_t      r_state;
  bundle_t     r_main;
  bundle_t     r_skid;
  logic        r_in_ready;
  logic        r_out_valid;

  assign w_instr = bus.instr_i;
  assign w_imm_i = {{20{w_instr[31]}}, w_instr[31:20]};
  assign w_imm_s = {{20{w_instr[31]}}, w_instr[31:25], w_instr[11:7]};
  assign w_imm_b = {{19{w_instr[31]}}, w_instr[31], w_instr[7], w_instr[30:25],
                    w_instr[11:8], 1'b0};
  assign w_imm_u = {w_instr[31:12], 12'h000};
  assign w_imm_j = {{11{w_instr[31]}}, w_instr[31], w_instr[19:12], w_instr[20],
                    w_instr[30:21], 1'b0};

  // Register fields pass through even for illegal words so execute can report them.
  always_comb begin
    w_dec     = '0;
    w_dec.pc  = bus.pc_i;
    w_dec.rd  = w_instr[11:7];
    w_dec.rs1 = w_instr[19:15];
    w_dec.rs2 = w_instr[24:20];
    w_dec.f3  = w_instr[14:12];
    w_dec.alt = w_instr[30];
    w_dec.cls = c_CLS_ILLEGAL;
    w_dec.imm = '0;
    if (w_instr[1:0] == 2'b11) begin
      case (w_instr[6:2])
        c_OP_LUI:      begin w_dec.cls = c_CLS_LUI;      w_dec.imm = w_imm_u; end
        c_OP_AUIPC:    begin w_dec.cls = c_CLS_AUIPC;    w_dec.imm = w_imm_u; end
        c_OP_JAL:      begin w_dec.cls = c_CLS_JAL;      w_dec.imm = w_imm_j; end
        c_OP_JALR:     begin w_dec.cls = c_CLS_JALR;     w_dec.imm = w_imm_i; end
        c_OP_BRANCH:   begin w_dec.cls = c_CLS_BRANCH;   w_dec.imm = w_imm_b; end
        c_OP_LOAD:     begin w_dec.cls = c_CLS_LOAD;     w_dec.imm = w_imm_i; end
        c_OP_STORE:    begin w_dec.cls = c_CLS_STORE;    w_dec.imm = w_imm_s; end
        c_OP_OP_IMM:   begin w_dec.cls = c_CLS_OP_IMM;   w_dec.imm = w_imm_i; end
        c_OP_OP:       w_dec.cls = c_CLS_OP;
        c_OP_MISC_MEM: w_dec.cls = c_CLS_MISC_MEM;
        c_OP_SYSTEM:   begin w_dec.cls = c_CLS_SYSTEM;   w_dec.imm = w_imm_i; end
        default:       w_dec.cls = c_CLS_ILLEGAL;
      endcase
    end
  end

  assign w_accept = bus.input_valid_i && r_in_ready;
  assign w_fire   = r_out_valid && bus.output_ready_i;

`ifdef ECAP5_DPROC_EARLY_JAL_EN
  logic        w_is_jal;
  logic        r_discard;
  logic        r_branch;
  logic [19:0] r_boffset;

  assign w_is_jal = (w_instr[1:0] == 2'b11) && (w_instr[6:2] == c_OP_JAL);
  // A word accepted while a discard is pending is the wrong-path fetch after a JAL.
  assign w_load   = w_accept && !r_discard;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_discard <= 1'b0;
      r_branch  <= 1'b0;
      r_boffset <= '0;
    end else begin
      r_branch  <= 1'b0;
      r_boffset <= '0;
      if (flush_i) begin
        r_discard <= 1'b0;
      end else if (w_accept) begin
        if (r_discard) begin
          r_discard <= 1'b0;
        end else if (w_is_jal) begin
          r_discard <= 1'b1;
          r_branch  <= 1'b1;
          r_boffset <= w_imm_j[19:0];
        end
      end
    end
  end

  assign bus.branch_o  = r_branch;
  assign bus.boffset_o = r_boffset;
`else
  assign w_load        = w_accept;
  assign bus.branch_o  = 1'b0;
  assign bus.boffset_o = '0;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= S_EMPTY;
      r_main      <= '0;
      r_skid      <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else if (flush_i) begin
      r_state     <= S_EMPTY;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        S_EMPTY: begin
          if (w_load) begin
            r_main      <= w_dec;
            r_state     <= S_BUSY;
            r_out_valid <= 1'b1;
          end
        end
        S_BUSY: begin
          if (w_fire) begin
            if (w_load) begin
              r_main <= w_dec;
            end else begin
              r_state     <= S_EMPTY;
              r_out_valid <= 1'b0;
            end
          end else if (w_load) begin
            r_skid     <= w_dec;
            r_state    <= S_FULL;
            r_in_ready <= 1'b0;
          end
        end
        S_FULL: begin
          if (w_fire) begin
            r_main     <= r_skid;
            r_state    <= S_BUSY;
            r_in_ready <= 1'b1;
          end
        end
        default: begin
          r_state     <= S_EMPTY;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.input_ready_o  = r_in_ready;
  assign bus.output_valid_o = r_out_valid;
  assign bus.pc_o           = r_main.pc;
  assign bus.op_class_o     = r_main.cls;
  assign bus.rd_o           = r_main.rd;
  assign bus.rs1_o          = r_main.rs1;
  assign bus.rs2_o          = r_main.rs2;
  assign bus.func3_o        = r_main.f3;
  assign bus.alt_o          = r_main.alt;
  assign bus.imm_o          = r_main.imm;

endmodule
`default_nettype wire

// File: tb/tb_decm.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_decm : vector table, corner sequences and randomized queue-model run  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_decm;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;

  always #5 clk = ~clk;

  decm_if bus ();

  decm dut (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .flush_i (flush),
    .bus     (bus)
  );

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [3:0]  cls;
    logic [31:0] imm;
  } vec_t;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } ent_t;

  vec_t        vt[15];
  ent_t        q[$];
  bit          discard = 1'b0;
  bit          exp_branch = 1'b0;
  logic [19:0] exp_boff = '0;
  int          n_vec = 0;
  int          n_err = 0;
  logic [6:0]  ops[11] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03,
                           7'h23, 7'h13, 7'h33, 7'h0F, 7'h73};

  // Instruction class straight from the full 7-bit opcode table.
  function automatic logic [3:0] ref_class(input logic [31:0] w);
    if (w[1:0] != 2'b11) return 4'd15;
    case (w[6:0])
      7'h37:   return 4'd0;
      7'h17:   return 4'd1;
      7'h6F:   return 4'd2;
      7'h67:   return 4'd3;
      7'h63:   return 4'd4;
      7'h03:   return 4'd5;
      7'h23:   return 4'd6;
      7'h13:   return 4'd7;
      7'h33:   return 4'd8;
      7'h0F:   return 4'd9;
      7'h73:   return 4'd10;
      default: return 4'd15;
    endcase
  endfunction

  function automatic logic [31:0] ref_imm(input logic [31:0] w);
    int s;
    s = $signed(w);
    case (ref_class(w))
      4'd3, 4'd5, 4'd7, 4'd10: return 32'(s >>> 20);
      4'd6: return 32'(((s >>> 25) <<< 5) | int'(w[11:7]));
      4'd4: return 32'(((s >>> 31) <<< 12) | (int'(w[7]) << 11) |
                       (int'(w[30:25]) << 5) | (int'(w[11:8]) << 1));
      4'd0, 4'd1: return w & 32'hFFFFF000;
      4'd2: return 32'(((s >>> 31) <<< 20) | (int'(w[19:12]) << 12) |
                       (int'(w[20]) << 11) | (int'(w[30:21]) << 1));
      default: return 32'h0;
    endcase
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] got_bundle();
    return 128'({bus.pc_o, bus.op_class_o, bus.rd_o, bus.rs1_o, bus.rs2_o,
                 bus.func3_o, bus.alt_o, bus.imm_o});
  endfunction

  function automatic logic [127:0] exp_bundle(input ent_t e);
    return 128'({e.pc, ref_class(e.instr), e.instr[11:7], e.instr[19:15],
                 e.instr[24:20], e.instr[14:12], e.instr[30], ref_imm(e.instr)});
  endfunction

  task automatic check_model(input string tag);
    chk({tag, "_valid"}, 128'(bus.output_valid_o), 128'(q.size() > 0));
    chk({tag, "_ready"}, 128'(bus.input_ready_o), 128'(q.size() < 2));
    if (q.size() > 0) chk({tag, "_bundle"}, got_bundle(), exp_bundle(q[0]));
    chk({tag, "_branch"}, 128'({bus.branch_o, bus.boffset_o}), 128'({exp_branch, exp_boff}));
  endtask

  // Drive one cycle of inputs from a negedge, advance the queue model, check at the next negedge.
  task automatic step(input string tag, input logic v, input logic [31:0] ins,
                      input logic [31:0] pc, input logic rdy, input logic fl);
    bit          fire;
    bit          acc;
    logic [31:0] jimm;
    bus.input_valid_i  = v;
    bus.instr_i        = ins;
    bus.pc_i           = pc;
    bus.output_ready_i = rdy;
    flush              = fl;
    fire       = (q.size() > 0) && rdy;
    acc        = v && (q.size() < 2);
    exp_branch = 1'b0;
    exp_boff   = '0;
    jimm       = ref_imm(ins);
    if (fl) begin
      q.delete();
      discard = 1'b0;
    end else begin
      if (fire) void'(q.pop_front());
      if (acc) begin
        if (discard) begin
          discard = 1'b0;
        end else begin
          q.push_back('{ins, pc});
`ifdef ECAP5_DPROC_EARLY_JAL_EN
          if (ref_class(ins) == 4'd2) begin
            discard    = 1'b1;
            exp_branch = 1'b1;
            exp_boff   = jimm[19:0];
          end
`endif
        end
      end
    end
    @(negedge clk);
    check_model(tag);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] r_instr;

    vt[0]  = '{32'h00510093, 32'h100, 4'd7,  32'h00000005};
    vt[1]  = '{32'hFE512E23, 32'h104, 4'd6,  32'hFFFFFFFC};
    vt[2]  = '{32'h00000000, 32'h108, 4'd15, 32'h00000000};
    vt[3]  = '{32'h123452B7, 32'h10C, 4'd0,  32'h12345000};
    vt[4]  = '{32'hFFFFF117, 32'h110, 4'd1,  32'hFFFFF000};
    vt[5]  = '{32'h00008067, 32'h114, 4'd3,  32'h00000000};
    vt[6]  = '{32'hFE000EE3, 32'h118, 4'd4,  32'hFFFFFFFC};
    vt[7]  = '{32'hFFF02183, 32'h11C, 4'd5,  32'hFFFFFFFF};
    vt[8]  = '{32'h003100B3, 32'h120, 4'd8,  32'h00000000};
    vt[9]  = '{32'h403100B3, 32'h124, 4'd8,  32'h00000000};
    vt[10] = '{32'h0FF0000F, 32'h128, 4'd9,  32'h00000000};
    vt[11] = '{32'h00000073, 32'h12C, 4'd10, 32'h00000000};
    vt[12] = '{32'h00100073, 32'h130, 4'd10, 32'h00000001};
    vt[13] = '{32'h00510090, 32'h134, 4'd15, 32'h00000000};
    vt[14] = '{32'h0000007F, 32'h138, 4'd15, 32'h00000000};

    bus.input_valid_i  = 1'b0;
    bus.instr_i        = '0;
    bus.pc_i           = '0;
    bus.output_ready_i = 1'b0;

    #12;
    chk("rst_valid", 128'(bus.output_valid_o), 128'(0));
    chk("rst_data", got_bundle(), 128'(0));
    chk("rst_branch", 128'({bus.branch_o, bus.boffset_o}), 128'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ready", 128'(bus.input_ready_o), 128'(1));

    // Decode table, streamed back to back with execute always ready.
    for (int i = 0; i < 15; i++) begin
      step($sformatf("tbl%0d", i), 1'b1, vt[i].instr, vt[i].pc, 1'b1, 1'b0);
      chk($sformatf("tbl%0d_class", i), 128'(bus.op_class_o), 128'(vt[i].cls));
      chk($sformatf("tbl%0d_imm", i), 128'(bus.imm_o), 128'(vt[i].imm));
      chk($sformatf("tbl%0d_pc", i), 128'(bus.pc_o), 128'(vt[i].pc));
      chk($sformatf("tbl%0d_fields", i),
          128'({bus.rd_o, bus.rs1_o, bus.rs2_o, bus.func3_o, bus.alt_o}),
          128'({vt[i].instr[11:7], vt[i].instr[19:15], vt[i].instr[24:20],
                vt[i].instr[14:12], vt[i].instr[30]}));
    end
    step("drain", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Backpressure: fill main and skid, third word refused, then in-order drain.
    step("bp0", 1'b1, 32'h00100093, 32'h200, 1'b0, 1'b0);
    step("bp1", 1'b1, 32'h00200113, 32'h204, 1'b0, 1'b0);
    chk("bp_full_ready", 128'(bus.input_ready_o), 128'(0));
    step("bp2", 1'b1, 32'h00300193, 32'h208, 1'b0, 1'b0);
    chk("bp_hold_pc", 128'(bus.pc_o), 128'(32'h200));
    step("bp3", 1'b1, 32'h00300193, 32'h208, 1'b1, 1'b0);
    chk("bp_second_pc", 128'(bus.pc_o), 128'(32'h204));
    step("bp4", 1'b1, 32'h00300193, 32'h208, 1'b1, 1'b0);
    chk("bp_third_pc", 128'(bus.pc_o), 128'(32'h208));
    step("bp5", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    chk("bp_empty", 128'(bus.output_valid_o), 128'(0));

    // Flush while full with a word on offer.
    step("fl0", 1'b1, 32'h00400213, 32'h300, 1'b0, 1'b0);
    step("fl1", 1'b1, 32'h00500293, 32'h304, 1'b0, 1'b0);
    step("fl2", 1'b1, 32'h00600313, 32'h308, 1'b0, 1'b1);
    chk("fl_valid", 128'(bus.output_valid_o), 128'(0));
    chk("fl_ready", 128'(bus.input_ready_o), 128'(1));
    step("fl3", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    chk("fl_gone", 128'(bus.output_valid_o), 128'(0));

    // Asynchronous reset between clock edges while full.
    step("mr0", 1'b1, 32'h00700393, 32'h400, 1'b0, 1'b0);
    step("mr1", 1'b1, 32'h00800413, 32'h404, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("mr_valid", 128'(bus.output_valid_o), 128'(0));
    chk("mr_data", got_bundle(), 128'(0));
    chk("mr_ready", 128'(bus.input_ready_o), 128'(1));
    q.delete();
    discard    = 1'b0;
    exp_branch = 1'b0;
    exp_boff   = '0;
    bus.input_valid_i = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

`ifdef ECAP5_DPROC_EARLY_JAL_EN
    step("jal0", 1'b1, 32'h0080006F, 32'h500, 1'b1, 1'b0);
    chk("jal_branch", 128'(bus.branch_o), 128'(1));
    chk("jal_boff", 128'(bus.boffset_o), 128'(20'h00008));
    chk("jal_class", 128'(bus.op_class_o), 128'(2));
    chk("jal_imm", 128'(bus.imm_o), 128'(8));
    step("jal1", 1'b1, 32'h00510093, 32'h504, 1'b1, 1'b0);
    chk("jal_drop", 128'(bus.output_valid_o), 128'(0));
    chk("jal_pulse_end", 128'(bus.branch_o), 128'(0));
    step("jal2", 1'b1, 32'h00510093, 32'h508, 1'b1, 1'b0);
    chk("jal_next_pc", 128'(bus.pc_o), 128'(32'h508));
    step("jal3", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
`endif

    // Randomized traffic against the queue model.
    for (int i = 0; i < 600; i++) begin
      r_instr = $urandom;
      if ($urandom_range(3) != 0) r_instr[6:0] = ops[$urandom_range(10)];
      step("rnd", ($urandom_range(9) < 7), r_instr, $urandom & 32'hFFFFFFFC,
           ($urandom_range(9) < 6), ($urandom_range(29) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
